// File: rtl/bicubic_tap_acc.sv
//------------------------------------------------------------------------------
// Module : bicubic_tap_acc
// Brief  : 16-tap signed accumulator with round-half-up, shift and clamp.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bicubic_tap_acc #(
  parameter int FRAC_SHIFT = 16,
  parameter int OUT_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prod_vld_i,
  input  logic             prod_first_i,
  input  logic             prod_neg_i,
  input  logic [39:0]      prod_i,
  output logic             pix_vld_o,
  output logic [OUT_W-1:0] pix_out_o,
  output logic             kernel_err_o
);

  localparam logic signed [45:0] c_half = 46'sd1 <<< (FRAC_SHIFT - 1);
  localparam logic signed [45:0] c_max  = (46'sd1 <<< OUT_W) - 46'sd1;

  logic signed [44:0] acc_q, acc_d;
  logic signed [44:0] sum_q, sum_d;
  logic        [3:0]  tap_cnt_q, tap_cnt_d;
  logic               sum_vld_q, sum_vld_d;
  logic               err_q, err_d;
  logic               pix_vld_q, pix_vld_d;
  logic [OUT_W-1:0]   pix_q, pix_d;

  logic signed [44:0] w_term;
  logic signed [44:0] w_acc_next;
  logic signed [45:0] w_round;
  logic signed [45:0] w_shift;
  logic [OUT_W-1:0]   w_clamped;

  assign w_term     = prod_neg_i ? -$signed({5'b0, prod_i}) : $signed({5'b0, prod_i});
  assign w_acc_next = acc_q + w_term;

  always_comb begin
    acc_d     = acc_q;
    sum_d     = sum_q;
    tap_cnt_d = tap_cnt_q;
    sum_vld_d = 1'b0;
    err_d     = 1'b0;
    if (prod_vld_i) begin
      if (prod_first_i) begin
        acc_d     = w_term;
        tap_cnt_d = 4'd1;
        err_d     = (tap_cnt_q != 4'd0);
      end else if (tap_cnt_q == 4'd0) begin
        // orphan tap: no kernel is open, drop it
        err_d = 1'b1;
      end else if (tap_cnt_q == 4'd15) begin
        sum_d     = w_acc_next;
        sum_vld_d = 1'b1;
        tap_cnt_d = 4'd0;
        acc_d     = '0;
      end else begin
        acc_d     = w_acc_next;
        tap_cnt_d = tap_cnt_q + 4'd1;
      end
    end
  end

  // Sign-extend to 46 bits so the rounding constant cannot overflow the sum.
  assign w_round = $signed({sum_q[44], sum_q}) + c_half;
  assign w_shift = w_round >>> FRAC_SHIFT;

  always_comb begin
    w_clamped = w_shift[OUT_W-1:0];
    if (w_shift < 46'sd0) begin
      w_clamped = '0;
    end else if (w_shift > c_max) begin
      w_clamped = '1;
    end
  end

  always_comb begin
    pix_vld_d = sum_vld_q;
    pix_d     = sum_vld_q ? w_clamped : pix_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      sum_q     <= '0;
      tap_cnt_q <= '0;
      sum_vld_q <= 1'b0;
      err_q     <= 1'b0;
      pix_vld_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      tap_cnt_q <= tap_cnt_d;
      sum_vld_q <= sum_vld_d;
      err_q     <= err_d;
      pix_vld_q <= pix_vld_d;
      pix_q     <= pix_d;
    end
  end

  assign pix_vld_o    = pix_vld_q;
  assign pix_out_o    = pix_q;
  assign kernel_err_o = err_q;

endmodule

`default_nettype wire
